// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one external SRAM port between the VGA frame reader, the UART image
//   loader and the milestone decoder. It issues at most one access per clock.
//   VGA always wins. UART and the decoder take turns round-robin, except that
//   the decoder can hold a burst with DEC_lock_i, up to LOCK_MAX grants while
//   UART waits. Each issued read carries an owner tag through a READ_LATENCY
//   deep pipe, so returning data is steered to the master that asked for it.
//
// Ports
//   Clock_50, Resetn                  clock, synchronous active-low reset
//   VGA_*                             read-only requester (req/address/grant/rdata_valid)
//   UART_*                            write-only requester (req/address/wdata/grant)
//   DEC_*                             read/write requester with burst lock
//   read_data_o                       SRAM read data, passed through combinationally
//   SRAM_address_o/_write_data_o/_we_n_o   registered access to the SRAM controller
//   SRAM_read_data_i                  read data from the SRAM controller
//   owner_o                           last granted requester (0 none, 1 VGA, 2 UART, 3 DEC)

module sram_arbiter #(
    parameter int READ_LATENCY = 3,
    parameter int LOCK_MAX     = 8
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        VGA_req_i,
    input  logic [17:0] VGA_address_i,
    output logic        VGA_grant_o,
    output logic        VGA_rdata_valid_o,
    input  logic        UART_req_i,
    input  logic [17:0] UART_address_i,
    input  logic [15:0] UART_wdata_i,
    output logic        UART_grant_o,
    input  logic        DEC_req_i,
    input  logic        DEC_we_n_i,
    input  logic [17:0] DEC_address_i,
    input  logic [15:0] DEC_wdata_i,
    input  logic        DEC_lock_i,
    output logic        DEC_grant_o,
    output logic        DEC_rdata_valid_o,
    output logic [15:0] read_data_o,
    output logic [17:0] SRAM_address_o,
    output logic [15:0] SRAM_write_data_o,
    output logic        SRAM_we_n_o,
    input  logic [15:0] SRAM_read_data_i,
    output logic [1:0]  owner_o
);

    // The owner encoding also serves as the read tag; only NONE, VGA and DEC
    // ever enter the tag pipe.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_UART = 2'd2,
        OWN_DEC  = 2'd3
    } owner_e;

    localparam logic [3:0] LOCK_CAP = 4'(LOCK_MAX);

    logic        rr_dec_q, rr_dec_d;       // 1: decoder has the next turn
    logic        dec_own_q, dec_own_d;     // decoder holds lock ownership
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    owner_e      owner_q, owner_d;
    owner_e      tag_q [READ_LATENCY];
    owner_e      tag_d [READ_LATENCY];

    logic gnt_vga, gnt_uart, gnt_dec;
    logic dec_locked;

    // Arbitration. Lock ownership is not lost to a VGA grant, so a burst
    // resumes right after VGA steps in.
    always_comb begin
        gnt_vga    = 1'b0;
        gnt_uart   = 1'b0;
        gnt_dec    = 1'b0;
        dec_locked = dec_own_q && DEC_lock_i && DEC_req_i && (lock_cnt_q < LOCK_CAP);
        if (Resetn) begin
            if (VGA_req_i) begin
                gnt_vga = 1'b1;
            end else if (dec_locked) begin
                gnt_dec = 1'b1;
            end else if (UART_req_i && DEC_req_i) begin
                if (rr_dec_q) begin
                    gnt_dec = 1'b1;
                end else begin
                    gnt_uart = 1'b1;
                end
            end else if (UART_req_i) begin
                gnt_uart = 1'b1;
            end else if (DEC_req_i) begin
                gnt_dec = 1'b1;
            end
        end
    end

    always_comb begin
        rr_dec_d   = rr_dec_q;
        dec_own_d  = dec_own_q;
        lock_cnt_d = lock_cnt_q;

        if (gnt_uart) begin
            rr_dec_d  = 1'b1;
            dec_own_d = 1'b0;
        end else if (gnt_dec) begin
            rr_dec_d  = 1'b0;
            dec_own_d = 1'b1;
        end

        // Only counts grants that actually keep UART waiting.
        if (gnt_uart || !DEC_lock_i) begin
            lock_cnt_d = 4'd0;
        end else if (gnt_dec && UART_req_i && (lock_cnt_q != 4'hF)) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
        end
    end

    // Issue stage: address and data hold over idle cycles, we_n drops back high.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        owner_d = OWN_NONE;
        if (gnt_vga) begin
            addr_d  = VGA_address_i;
            owner_d = OWN_VGA;
        end else if (gnt_uart) begin
            addr_d  = UART_address_i;
            wdata_d = UART_wdata_i;
            we_n_d  = 1'b0;
            owner_d = OWN_UART;
        end else if (gnt_dec) begin
            addr_d  = DEC_address_i;
            wdata_d = DEC_wdata_i;
            we_n_d  = DEC_we_n_i;
            owner_d = OWN_DEC;
        end
    end

    // The tag enters the pipe from the access currently on the SRAM bus, so the
    // last stage lines up with data READ_LATENCY cycles after the address.
    always_comb begin
        if (owner_q == OWN_VGA) begin
            tag_d[0] = OWN_VGA;
        end else if ((owner_q == OWN_DEC) && we_n_q) begin
            tag_d[0] = OWN_DEC;
        end else begin
            tag_d[0] = OWN_NONE;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            rr_dec_q   <= 1'b0;
            dec_own_q  <= 1'b0;
            lock_cnt_q <= 4'd0;
            addr_q     <= 18'd0;
            wdata_q    <= 16'd0;
            we_n_q     <= 1'b1;
            owner_q    <= OWN_NONE;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= OWN_NONE;
            end
        end else begin
            rr_dec_q   <= rr_dec_d;
            dec_own_q  <= dec_own_d;
            lock_cnt_q <= lock_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            owner_q    <= owner_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign VGA_grant_o       = gnt_vga;
    assign UART_grant_o      = gnt_uart;
    assign DEC_grant_o       = gnt_dec;
    assign SRAM_address_o    = addr_q;
    assign SRAM_write_data_o = wdata_q;
    assign SRAM_we_n_o       = we_n_q;
    assign owner_o           = owner_q;
    assign read_data_o       = SRAM_read_data_i;
    // Gated by Resetn so stale tags never pulse during the reset cycle itself.
    assign VGA_rdata_valid_o = Resetn && (tag_q[READ_LATENCY-1] == OWN_VGA);
    assign DEC_rdata_valid_o = Resetn && (tag_q[READ_LATENCY-1] == OWN_DEC);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int RL = 3;

    logic        clk;
    logic        Resetn;
    logic        VGA_req_i;
    logic [17:0] VGA_address_i;
    logic        VGA_grant_o;
    logic        VGA_rdata_valid_o;
    logic        UART_req_i;
    logic [17:0] UART_address_i;
    logic [15:0] UART_wdata_i;
    logic        UART_grant_o;
    logic        DEC_req_i;
    logic        DEC_we_n_i;
    logic [17:0] DEC_address_i;
    logic [15:0] DEC_wdata_i;
    logic        DEC_lock_i;
    logic        DEC_grant_o;
    logic        DEC_rdata_valid_o;
    logic [15:0] read_data_o;
    logic [17:0] SRAM_address_o;
    logic [15:0] SRAM_write_data_o;
    logic        SRAM_we_n_o;
    logic [15:0] SRAM_read_data_i;
    logic [1:0]  owner_o;

    sram_arbiter #(.READ_LATENCY(RL), .LOCK_MAX(8)) dut (
        .Clock_50          (clk),
        .Resetn            (Resetn),
        .VGA_req_i         (VGA_req_i),
        .VGA_address_i     (VGA_address_i),
        .VGA_grant_o       (VGA_grant_o),
        .VGA_rdata_valid_o (VGA_rdata_valid_o),
        .UART_req_i        (UART_req_i),
        .UART_address_i    (UART_address_i),
        .UART_wdata_i      (UART_wdata_i),
        .UART_grant_o      (UART_grant_o),
        .DEC_req_i         (DEC_req_i),
        .DEC_we_n_i        (DEC_we_n_i),
        .DEC_address_i     (DEC_address_i),
        .DEC_wdata_i       (DEC_wdata_i),
        .DEC_lock_i        (DEC_lock_i),
        .DEC_grant_o       (DEC_grant_o),
        .DEC_rdata_valid_o (DEC_rdata_valid_o),
        .read_data_o       (read_data_o),
        .SRAM_address_o    (SRAM_address_o),
        .SRAM_write_data_o (SRAM_write_data_o),
        .SRAM_we_n_o       (SRAM_we_n_o),
        .SRAM_read_data_i  (SRAM_read_data_i),
        .owner_o           (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SRAM model: data is a fixed function of the address seen on the bus
    // RL cycles earlier.
    function automatic logic [15:0] mem_f(input logic [17:0] a);
        return (a == 18'h00100) ? 16'hABCD : (a[15:0] ^ 16'h5A5A);
    endfunction

    logic [17:0] hist [RL];
    always @(posedge clk) begin
        hist[0] <= SRAM_address_o;
        for (int i = 1; i < RL; i++) hist[i] <= hist[i-1];
    end
    assign SRAM_read_data_i = mem_f(hist[RL-1]);

    typedef struct {
        logic [1:0]  who;   // 1 VGA, 3 DEC
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Read-return monitor: valid must match the scoreboard exactly, nothing else.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rvalid_vga", 32'(VGA_rdata_valid_o), 32'(e.who == 2'd1));
            chk("rvalid_dec", 32'(DEC_rdata_valid_o), 32'(e.who == 2'd3));
            chk("rdata", 32'(read_data_o), 32'(e.data));
        end else begin
            chk("no_valid", 32'({VGA_rdata_valid_o, DEC_rdata_valid_o}), 32'd0);
        end
    end

    logic [17:0] exp_addr;
    logic [15:0] exp_wd;
    logic        exp_we;
    logic [1:0]  exp_own;

    task automatic set_reqs(input logic v, input logic u, input logic d,
                            input logic dwe, input logic dlk, input logic [17:0] base);
        VGA_req_i      = v;
        UART_req_i     = u;
        DEC_req_i      = d;
        DEC_we_n_i     = dwe;
        DEC_lock_i     = dlk;
        VGA_address_i  = base;
        UART_address_i = base + 18'd1;
        DEC_address_i  = base + 18'd2;
        UART_wdata_i   = base[15:0] ^ 16'h1111;
        DEC_wdata_i    = base[15:0] ^ 16'h2222;
    endtask

    // One clock: drive requests, check the bus from the previous edge and the
    // grant for this cycle, record what the edge should issue.
    task automatic step(input logic v, input logic u, input logic d,
                        input logic dwe, input logic dlk, input logic [17:0] base,
                        input logic [1:0] exp_g);
        logic [2:0] g1h;
        set_reqs(v, u, d, dwe, dlk, base);
        #2;
        chk("bus_addr", 32'(SRAM_address_o), 32'(exp_addr));
        chk("bus_wdata", 32'(SRAM_write_data_o), 32'(exp_wd));
        chk("bus_we_n", 32'(SRAM_we_n_o), 32'(exp_we));
        chk("owner", 32'(owner_o), 32'(exp_own));
        case (exp_g)
            2'd1:    g1h = 3'b100;
            2'd2:    g1h = 3'b010;
            2'd3:    g1h = 3'b001;
            default: g1h = 3'b000;
        endcase
        chk("grant", 32'({VGA_grant_o, UART_grant_o, DEC_grant_o}), 32'(g1h));
        exp_we  = 1'b1;
        exp_own = exp_g;
        case (exp_g)
            2'd1: begin
                exp_addr = VGA_address_i;
                sb.push_back('{2'd1, mem_f(VGA_address_i), cyc + 1 + RL});
            end
            2'd2: begin
                exp_addr = UART_address_i;
                exp_wd   = UART_wdata_i;
                exp_we   = 1'b0;
            end
            2'd3: begin
                exp_addr = DEC_address_i;
                exp_wd   = DEC_wdata_i;
                exp_we   = DEC_we_n_i;
                if (DEC_we_n_i) sb.push_back('{2'd3, mem_f(DEC_address_i), cyc + 1 + RL});
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 2'd0);
    endtask

    // Requests are held high through reset to show grants stay low.
    task automatic do_reset();
        sb.delete();
        Resetn = 1'b0;
        set_reqs(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h3FF00);
        #2;
        chk("rst_grant", 32'({VGA_grant_o, UART_grant_o, DEC_grant_o}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_grant2", 32'({VGA_grant_o, UART_grant_o, DEC_grant_o}), 32'd0);
        chk("rst_addr", 32'(SRAM_address_o), 32'd0);
        chk("rst_wdata", 32'(SRAM_write_data_o), 32'd0);
        chk("rst_we_n", 32'(SRAM_we_n_o), 32'd1);
        chk("rst_owner", 32'(owner_o), 32'd0);
        Resetn = 1'b1;
        set_reqs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h0);
        exp_addr = 18'd0;
        exp_wd   = 16'd0;
        exp_we   = 1'b1;
        exp_own  = 2'd0;
    endtask

    initial begin
        Resetn = 1'b0;
        set_reqs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h0);

        // Single decoder read of 0x00100 (base + 2).
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'h000FE, 2'd3);
        idle(6);

        // UART and decoder both busy, no lock: U, D, U, D ... starting with UART.
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 1'b1, 1'((i / 2) % 2 == 1), 1'b0,
                 18'h01000 + 18'(i * 4), (i % 2 == 0) ? 2'd2 : 2'd3);
        idle(5);

        // VGA every other cycle over busy UART/decoder.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] eg;
            if (i % 2 == 0)      eg = 2'd1;
            else if (i % 4 == 1) eg = 2'd2;
            else                 eg = 2'd3;
            step(1'((i % 2) == 0), 1'b1, 1'b1, 1'b1, 1'b0, 18'h02000 + 18'(i * 4), eg);
        end
        idle(5);

        // Decoder lock: 8 locked grants with UART waiting (a VGA cycle in the
        // middle leaves the count and ownership alone), then UART.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'h03000, 2'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 18'h03010 + 18'(i * 4), 2'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h03040, 2'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 18'h03050 + 18'(i * 4), 2'd3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 18'h03070, 2'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 18'h03080, 2'd3);
        // Only a cleared lock count lets the decoder win again over waiting UART.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 18'h03090, 2'd3);
        idle(5);

        // Three reads in flight, then reset: no valids afterwards, UART first.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'h04000 + 18'(i * 4), 2'd3);
        do_reset();
        idle(6);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 18'h05000, 2'd2);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
